deck_shuffle_ctrl: RTL and testbench

- Sequencer owning the 52-card deck store and the 6-bit LFSR used for shuffling.
- On request it initialises the deck, performs a fixed number of LFSR-driven swap passes, then serves cards one at a time to the dealer/player logic over a request/valid handshake.
- Replaces the unclocked, loop-based shuffle/deal with a clocked, single-swap-per-cycle datapath.

---
 rtl/deck_shuffle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_deck_shuffle_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_shuffle_ctrl.sv
// rtl/deck_shuffle_ctrl.sv - deck store, LFSR swap shuffler and one-card-per-request dealer
module deck_shuffle_ctrl #(
    parameter int DECK_SIZE = 52,
    parameter int IDX_W     = 6,
    parameter int SWAPS     = 52
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_shuffle_req,
    input  logic [IDX_W-1:0] i_seed,
    input  logic             i_deal_req,
    output logic             o_busy,
    output logic             o_card_valid,
    output logic [IDX_W-1:0] o_card,
    output logic [3:0]       o_card_value,
    output logic [IDX_W-1:0] o_cards_left,
    output logic             o_deck_empty
);

    localparam int               SW_W         = (SWAPS > 1) ? $clog2(SWAPS) : 1;
    localparam logic [IDX_W-1:0] LP_DECK      = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] LP_LAST      = IDX_W'(DECK_SIZE - 1);
    localparam logic [SW_W-1:0]  LP_SWAP_LAST = SW_W'(SWAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_READY
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;
    logic             w_init_done;
    logic             w_swap_done;
    logic             w_deal;

    logic [IDX_W-1:0] r_lfsr;
    logic [IDX_W-1:0] r_idx;
    logic [SW_W-1:0]  r_swap_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;
    logic             r_card_valid;
    logic [IDX_W-1:0] r_card;
    logic [3:0]       r_card_value;
    logic [IDX_W-1:0] r_cards_left;
    logic             r_deck_empty;
    logic [IDX_W-1:0] r_deck [DECK_SIZE];

    logic [IDX_W-1:0] w_lfsr_a;
    logic [IDX_W-1:0] w_lfsr_b;
    logic [IDX_W-1:0] w_a;
    logic [IDX_W-1:0] w_b;
    logic [IDX_W-1:0] w_deck_a;
    logic [IDX_W-1:0] w_deck_b;

    // x^6+x^5+1 Fibonacci step: shift left, feed back b5^b4
    function automatic logic [IDX_W-1:0] lfsr_step(input logic [IDX_W-1:0] v);
        return {v[IDX_W-2:0], v[IDX_W-1] ^ v[IDX_W-2]};
    endfunction

    // Fold LFSR values beyond the deck back into range
    function automatic logic [IDX_W-1:0] idx_map(input logic [IDX_W-1:0] r);
        return (r >= LP_DECK) ? (r - LP_DECK) : r;
    endfunction

    // Blackjack value: rank = card mod 13, ace=1, face cards capped at 10
    function automatic logic [3:0] card_val(input logic [IDX_W-1:0] c);
        logic [IDX_W-1:0] m;
        m = c % IDX_W'(13);
        return (m >= IDX_W'(9)) ? 4'd10 : (m[3:0] + 4'd1);
    endfunction

    assign w_lfsr_a = lfsr_step(r_lfsr);
    assign w_lfsr_b = lfsr_step(w_lfsr_a);
    assign w_a      = idx_map(w_lfsr_a);
    assign w_b      = idx_map(w_lfsr_b);
    assign w_deck_a = r_deck[w_a];
    assign w_deck_b = r_deck[w_b];

    // Next state and per-cycle control strobes; shuffle beats deal in READY
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_init_done = 1'b0;
        w_swap_done = 1'b0;
        w_deal      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_shuffle_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (r_idx == LP_LAST) begin
                    w_init_done = 1'b1;
                    w_state_nxt = S_SHUFFLE;
                end
            end
            S_SHUFFLE: begin
                if (r_swap_cnt == LP_SWAP_LAST) begin
                    w_swap_done = 1'b1;
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (i_shuffle_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_INIT;
                end else if (i_deal_req && (r_ptr < LP_DECK)) begin
                    w_deal = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencing counters, LFSR and dealer outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr       <= IDX_W'(1);
            r_idx        <= '0;
            r_swap_cnt   <= '0;
            r_ptr        <= '0;
            r_busy       <= 1'b0;
            r_card_valid <= 1'b0;
            r_card       <= '0;
            r_card_value <= '0;
            r_cards_left <= '0;
            r_deck_empty <= 1'b1;
        end else begin
            r_card_valid <= w_deal;
            if (w_start) begin
                r_lfsr       <= (i_seed == '0) ? IDX_W'(1) : i_seed;
                r_idx        <= '0;
                r_ptr        <= '0;
                r_busy       <= 1'b1;
                r_deck_empty <= 1'b1;
                r_cards_left <= '0;
            end else if (r_state == S_INIT) begin
                r_idx      <= w_init_done ? '0 : (r_idx + IDX_W'(1));
                r_swap_cnt <= '0;
            end else if (r_state == S_SHUFFLE) begin
                r_lfsr     <= w_lfsr_b;
                r_swap_cnt <= r_swap_cnt + SW_W'(1);
                if (w_swap_done) begin
                    r_ptr        <= '0;
                    r_cards_left <= LP_DECK;
                    r_deck_empty <= 1'b0;
                    r_busy       <= 1'b0;
                end
            end else if (w_deal) begin
                r_card       <= r_deck[r_ptr];
                r_card_value <= card_val(r_deck[r_ptr]);
                r_ptr        <= r_ptr + IDX_W'(1);
                r_cards_left <= r_cards_left - IDX_W'(1);
                if (r_ptr == LP_LAST) begin
                    r_deck_empty <= 1'b1;
                end
            end
        end
    end

    // Deck store: identity fill in INIT, one two-entry swap per SHUFFLE cycle
    always_ff @(posedge i_clk) begin
        if (r_state == S_INIT) begin
            r_deck[r_idx] <= r_idx;
        end else if (r_state == S_SHUFFLE) begin
            r_deck[w_a] <= w_deck_b;
            r_deck[w_b] <= w_deck_a;
        end
    end

    assign o_busy       = r_busy;
    assign o_card_valid = r_card_valid;
    assign o_card       = r_card;
    assign o_card_value = r_card_value;
    assign o_cards_left = r_cards_left;
    assign o_deck_empty = r_deck_empty;

endmodule

// File: tb/tb_deck_shuffle_ctrl.sv
// tb/tb_deck_shuffle_ctrl.sv - self-checking bench for deck_shuffle_ctrl
module tb_deck_shuffle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       shuffle_req = 1'b0;
    logic [5:0] seed = '0;
    logic       deal_req = 1'b0;
    logic       busy;
    logic       card_valid;
    logic [5:0] card;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;

    int checks = 0;
    int errors = 0;
    int exp_seq[52];
    int got_seq[52];
    int save_a[52];
    int m20[52];
    int got_n;

    deck_shuffle_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_shuffle_req(shuffle_req),
        .i_seed       (seed),
        .i_deal_req   (deal_req),
        .o_busy       (busy),
        .o_card_valid (card_valid),
        .o_card       (card),
        .o_card_value (card_value),
        .o_cards_left (cards_left),
        .o_deck_empty (deck_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lfsr_nxt(input int v);
        return ((v << 1) & 63) | (((v >> 5) ^ (v >> 4)) & 1);
    endfunction

    function automatic int fold(input int r);
        return (r >= 52) ? r - 52 : r;
    endfunction

    function automatic int bj(input int c);
        int v;
        v = (c % 13) + 1;
        return (v > 10) ? 10 : v;
    endfunction

    // Reference: identity deck, 52 LFSR-driven swaps, deal order = final deck order
    task automatic model(input int sd);
        int d[52];
        int lf, a, b, t;
        lf = (sd == 0) ? 1 : sd;
        for (int i = 0; i < 52; i++) d[i] = i;
        for (int s = 0; s < 52; s++) begin
            lf = lfsr_nxt(lf);
            a  = fold(lf);
            lf = lfsr_nxt(lf);
            b  = fold(lf);
            t = d[a]; d[a] = d[b]; d[b] = t;
        end
        exp_seq = d;
    endtask

    task automatic shuffle_timed(input int sd, input bit hold_deal);
        int lat;
        bit saw_valid;
        shuffle_req = 1'b1;
        seed        = 6'(sd);
        deal_req    = hold_deal;
        step();
        shuffle_req = 1'b0;
        chk("busy_set", busy, 1);
        lat = 0;
        saw_valid = 0;
        while (busy && lat < 300) begin
            step();
            lat++;
            if (card_valid) saw_valid = 1;
        end
        deal_req = 1'b0;
        chk("busy_latency", lat, 104);
        chk("no_deal_while_busy", saw_valid, 0);
        chk("cards_left_full", cards_left, 52);
        chk("deck_empty_clear", deck_empty, 0);
    endtask

    task automatic deal_n(input int target, input bit gaps);
        int cyc;
        cyc = 0;
        while (got_n < target && cyc < 400) begin
            deal_req = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
            if (card_valid) begin
                got_seq[got_n] = card;
                chk("card", card, exp_seq[got_n]);
                chk("card_value", card_value, bj(exp_seq[got_n]));
                got_n++;
                chk("cards_left_dec", cards_left, 52 - got_n);
            end
        end
        deal_req = 1'b0;
        chk("deal_count", got_n, target);
    endtask

    task automatic deal_all(input bit gaps);
        int seen[52];
        bit perm_ok;
        got_n = 0;
        deal_n(52, gaps);
        deal_req = 1'b1;
        step();
        deal_req = 1'b0;
        chk("no_53rd_pulse", card_valid, 0);
        chk("deck_empty_end", deck_empty, 1);
        chk("cards_left_end", cards_left, 0);
        chk("card_hold", card, exp_seq[51]);
        for (int i = 0; i < 52; i++) seen[i] = 0;
        for (int i = 0; i < 52; i++) if (got_seq[i] >= 0 && got_seq[i] < 52) seen[got_seq[i]]++;
        perm_ok = 1;
        for (int i = 0; i < 52; i++) if (seen[i] != 1) perm_ok = 0;
        chk("permutation", perm_ok, 1);
    endtask

    initial begin
        bit same;
        bit exp_diff;
        int sd, sd2, lat;

        // reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", card_valid, 0);
        chk("rst_card", card, 0);
        chk("rst_value", card_value, 0);
        chk("rst_left", cards_left, 0);
        chk("rst_empty", deck_empty, 1);
        step();
        rst_n = 1'b1;
        deal_req = 1'b1;
        step();
        deal_req = 1'b0;
        chk("idle_deal_ignored", card_valid, 0);

        // latency with deal_req held, then full deal
        model(20);
        m20 = exp_seq;
        shuffle_timed(20, 1);
        deal_all(0);
        save_a = got_seq;

        // same seed twice
        shuffle_timed(20, 0);
        deal_all(1);
        same = 1;
        for (int i = 0; i < 52; i++) if (got_seq[i] != save_a[i]) same = 0;
        chk("seed20_repeat_same", same, 1);

        // seed 0 behaves as seed 1
        model(0);
        shuffle_timed(0, 0);
        deal_all(0);
        save_a = got_seq;
        model(1);
        shuffle_timed(1, 0);
        deal_all(0);
        same = 1;
        for (int i = 0; i < 52; i++) if (got_seq[i] != save_a[i]) same = 0;
        chk("seed0_eq_seed1", same, 1);

        // seed 5 vs seed 20
        model(5);
        exp_diff = 0;
        for (int i = 0; i < 52; i++) if (exp_seq[i] != m20[i]) exp_diff = 1;
        shuffle_timed(5, 0);
        deal_all(0);
        same = 1;
        for (int i = 0; i < 52; i++) if (got_seq[i] != m20[i]) same = 0;
        chk("seed5_vs_seed20_differ", !same, exp_diff);

        // random seeds
        for (int k = 0; k < 4; k++) begin
            sd = int'($urandom_range(0, 63));
            model(sd);
            shuffle_timed(sd, 0);
            deal_all(1);
        end

        // shuffle+deal collision with 30 cards left, then ignored mid-shuffle request
        sd  = int'($urandom_range(0, 63));
        sd2 = int'($urandom_range(0, 63));
        model(sd);
        shuffle_timed(sd, 0);
        got_n = 0;
        deal_n(22, 0);
        chk("left_30", cards_left, 30);
        shuffle_req = 1'b1;
        deal_req    = 1'b1;
        seed        = 6'(sd2);
        step();
        shuffle_req = 1'b0;
        deal_req    = 1'b0;
        chk("collision_no_valid", card_valid, 0);
        chk("collision_busy", busy, 1);
        lat = 0;
        while (busy && lat < 300) begin
            step();
            lat++;
            shuffle_req = (lat == 60);
            seed = 6'(sd2 ^ 6'h2a);
        end
        shuffle_req = 1'b0;
        chk("mid_shuffle_req_latency", lat, 104);
        model(sd2);
        deal_all(0);

        // reset mid-deal
        model(20);
        shuffle_timed(20, 0);
        deal_req = 1'b1;
        step();
        step();
        chk("pre_reset_valid", card_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        deal_req = 1'b0;
        chk("rst_deal_valid", card_valid, 0);
        chk("rst_deal_left", cards_left, 0);
        chk("rst_deal_empty", deck_empty, 1);
        step();
        rst_n = 1'b1;
        deal_req = 1'b1;
        step();
        step();
        deal_req = 1'b0;
        chk("post_reset_no_deal", card_valid, 0);

        // reset mid-shuffle
        shuffle_req = 1'b1;
        seed = 6'd20;
        step();
        shuffle_req = 1'b0;
        repeat (70) step();
        chk("mid_shuffle_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_shuf_busy", busy, 0);
        chk("rst_shuf_empty", deck_empty, 1);
        chk("rst_shuf_left", cards_left, 0);
        chk("rst_shuf_valid", card_valid, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
